fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_queue.sv | 78 +++++++
 tb/tb_fetch_queue.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Processor-wide constants shared by the fetch and decode stages.
// Purpose: shared constants; no logic, no latency, no flow control.
package fetch_queue_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          STEP_DEF     = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'd0;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: first-word-fall-through storage with count and synchronous flush.
// Latency: push visible at head one cycle later; push while full only lands if a pop frees the slot.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign head_dat = mem[head];

  // Flush discards both the pending pop and any push in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage is deliberately left unreset; occupancy alone marks validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_dat;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generation into a prefetch queue; redirect flushes and refetches (2 cycles to out_valid).
// Backpressure: fetch stalls while the queue is full unless the head is popped the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              STEP     = STEP_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [XLEN-1:0]        imem_addr,
  output logic                   imem_req,
  input  logic [XLEN-1:0]        imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              SB         = $clog2(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << SB) - XLEN'(1));

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  entry_t          push_ent;
  entry_t          head_ent;
  logic            empty;
  logic            full;
  logic            pop;

  assign imem_addr = pc_q;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  // Held low while in reset so no request leaks out before the PC is known.
  assign imem_req  = rst_n & fetch_en & ~redirect_valid & (~full | pop);

  assign push_ent.pc    = pc_q;
  assign push_ent.instr = imem_rdata;
  assign out_pc         = head_ent.pc;
  assign out_instr      = head_ent.instr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ALIGN_MASK;
    end else if (imem_req) begin
      pc_q <= pc_q + XLEN'(STEP);
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (imem_req),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue with default parameters (XLEN=32, DEPTH=4, STEP=4, RESET_PC=0).
module tb_fetch_queue;

  localparam logic [31:0] IMASK = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .count          (count)
  );

  assign imem_rdata = imem_addr ^ IMASK;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst_n;
    logic        fe;
    logic        rv;
    logic [31:0] rpc;
    logic        ro;
    logic        exp_req;   // imem_req before the edge
    logic [2:0]  exp_cnt;   // state after the edge
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;    // head PC, checked only when exp_cnt != 0
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic fe, logic rv, logic [31:0] rpc, logic ro,
                              logic req, logic [2:0] cnt, logic [31:0] addr, logic [31:0] pc);
    vec_t v;
    v.rst_n = r; v.fe = fe; v.rv = rv; v.rpc = rpc; v.ro = ro;
    v.exp_req = req; v.exp_cnt = cnt; v.exp_addr = addr; v.exp_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [vec %0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    //                 rst fe rv rpc           ro  req cnt addr          head pc
    vecs.push_back(mk(0, 1, 0, 32'h0,        0,  0,  0,  32'h0,        32'h0));        // reset
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,  1,  1,  32'h4,        32'h0));        // stream 0,4,8,12
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,  1,  1,  32'h8,        32'h4));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,  1,  1,  32'hC,        32'h8));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,  1,  1,  32'h10,       32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0,  0,  0,  32'h0,        32'h0));        // reset mid-stream
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  1,  32'h4,        32'h0));        // fill
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  2,  32'h8,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  3,  32'hC,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  4,  32'h10,       32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  0,  4,  32'h10,       32'h0));        // full stall
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,  1,  4,  32'h14,       32'h4));        // pop+push while full
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,  1,  4,  32'h18,       32'h8));
    vecs.push_back(mk(1, 1, 1, 32'h200,      1,  0,  0,  32'h200,      32'h0));        // flush beats pop
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  1,  32'h204,      32'h200));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0,  0,  1,  32'h204,      32'h200));      // fetch_en low holds
    vecs.push_back(mk(1, 0, 0, 32'h0,        1,  0,  0,  32'h204,      32'h0));        // pop only
    vecs.push_back(mk(1, 0, 0, 32'h0,        1,  0,  0,  32'h204,      32'h0));        // ready on empty
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  1,  32'h208,      32'h204));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  2,  32'h20C,      32'h204));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  3,  32'h210,      32'h204));
    vecs.push_back(mk(1, 1, 1, 32'h103,      0,  0,  0,  32'h100,      32'h0));        // unaligned redirect
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  1,  32'h104,      32'h100));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  2,  32'h108,      32'h100));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  3,  32'h10C,      32'h100));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0,  1,  4,  32'h110,      32'h100));
    vecs.push_back(mk(0, 1, 1, 32'h300,      1,  0,  0,  32'h0,        32'h0));        // reset beats redirect
    vecs.push_back(mk(1, 1, 1, 32'hFFFF_FFF8, 0, 0,  0,  32'hFFFF_FFF8, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,  1,  1,  32'hFFFF_FFFC, 32'hFFFF_FFF8));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,  1,  1,  32'h0,        32'hFFFF_FFFC)); // PC wrap
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,  1,  1,  32'h4,        32'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; fetch_en = vecs[i].fe; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].ro;
      #1;
      chk("imem_req", i, 32'(imem_req), 32'(vecs[i].exp_req));
      @(posedge clk);
      #1;
      chk("count", i, 32'(count), 32'(vecs[i].exp_cnt));
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_cnt != 3'd0));
      chk("imem_addr", i, imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_cnt != 3'd0) begin
        chk("out_pc", i, out_pc, vecs[i].exp_pc);
        chk("out_instr", i, out_instr, vecs[i].exp_pc ^ IMASK);
      end
    end

    // Reset held two cycles with fetch_en and out_ready high: no requests leak.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
      #1;
      chk("req_in_reset", 100 + k, 32'(imem_req), 32'd0);
      @(posedge clk);
      #1;
      chk("count_in_reset", 100 + k, 32'(count), 32'd0);
      chk("addr_in_reset", 100 + k, imem_addr, 32'h0);
    end

    // Release: first fetch at RESET_PC, head valid one cycle later.
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    begin
      int cyc;
      cyc = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) break;
      end
      chk("release_valid", 200, 32'(out_valid), 32'd1);
      chk("release_latency", 200, 32'(cyc), 32'd1);
      chk("release_pc", 200, out_pc, 32'h0);
      chk("release_instr", 200, out_instr, IMASK);
      chk("release_addr", 200, imem_addr, 32'h4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
